// File: rtl/cache_pkg.sv
// Shared types and default geometry for the L1 line-fill controller.
package cache_pkg;

    // Miss-handler states: idle, dirty-victim write-back, line refill.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

    // Default cache geometry.
    localparam int DEF_ADDR_W         = 16;
    localparam int DEF_WORD_BYTES     = 2;
    localparam int DEF_WORDS_PER_LINE = 8;
    localparam int DEF_INDEX_W        = 6;

    // Address split derived from the defaults.
    localparam int DEF_BO_W  = $clog2(DEF_WORD_BYTES);
    localparam int DEF_WO_W  = $clog2(DEF_WORDS_PER_LINE);
    localparam int DEF_OFF_W = DEF_BO_W + DEF_WO_W;
    localparam int DEF_TAG_W = DEF_ADDR_W - DEF_INDEX_W - DEF_OFF_W;

endpackage

// File: rtl/cache_word_counter.sv
// Clear/enable up-counter with a terminal-value flag; used for the
// write-back, read-request and read-return word counters.
module cache_word_counter #(
    parameter int W    = 4,
    parameter int LAST = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last
);

    // Clear has priority over count so a new miss always starts at word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign last = (cnt == W'(LAST));

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// L1 miss handler: optional dirty-victim write-back followed by a pipelined
// word-by-word refill. fsm_busy stalls the pipeline for the whole miss.
module cache_line_fill_ctrl
    import cache_pkg::*;
#(
    parameter int  ADDR_W         = DEF_ADDR_W,
    parameter int  WORD_BYTES     = DEF_WORD_BYTES,
    parameter int  WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int  INDEX_W        = DEF_INDEX_W,
    parameter int  WB_EN          = 1,
    localparam int BO_W           = $clog2(WORD_BYTES),
    localparam int WO_W           = $clog2(WORDS_PER_LINE),
    localparam int OFF_W          = BO_W + WO_W,
    localparam int TAG_W          = ADDR_W - INDEX_W - OFF_W,
    localparam int LB_W           = ADDR_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              victim_dirty,
    input  logic [TAG_W-1:0]  victim_tag,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic              read_data_array,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [WO_W-1:0]   array_word
);

    state_t             state, state_nxt;
    logic [LB_W-1:0]    line_base;
    logic [TAG_W-1:0]   vic_tag;
    logic               vic_dirty;
    logic [INDEX_W-1:0] set_index;

    // One spare bit on each counter so a full line never wraps back to 0.
    logic [WO_W:0]      k_cnt, r_cnt, d_cnt;
    logic               k_last, d_last, unused_r_last;
    logic               cnt_clr, k_en, r_en, d_en;

    // Byte-offset bits of the miss address never reach memory.
    logic               unused_off;
    assign unused_off = ^miss_address[OFF_W-1:0];

    assign set_index = line_base[INDEX_W-1:0];
    assign cnt_clr   = (state == IDLE);
    assign fsm_busy  = (state != IDLE);

    cache_word_counter #(.W(WO_W+1), .LAST(WORDS_PER_LINE-1)) u_wb_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (k_en),
        .cnt   (k_cnt),
        .last  (k_last)
    );

    cache_word_counter #(.W(WO_W+1), .LAST(WORDS_PER_LINE-1)) u_req_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (r_en),
        .cnt   (r_cnt),
        .last  (unused_r_last)
    );

    cache_word_counter #(.W(WO_W+1), .LAST(WORDS_PER_LINE-1)) u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (d_en),
        .cnt   (d_cnt),
        .last  (d_last)
    );

    // State register; reset drops straight to IDLE so all outputs go low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Capture the missing line and victim identity when a miss is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_base <= '0;
            vic_tag   <= '0;
            vic_dirty <= 1'b0;
        end else if (state == IDLE && miss_detected) begin
            line_base <= miss_address[ADDR_W-1:OFF_W];
            vic_tag   <= victim_tag;
            vic_dirty <= victim_dirty;
        end
    end

    // Next-state and output decode; addresses are field concatenations
    // shifted up past the byte offset.
    always_comb begin
        state_nxt        = state;
        mem_addr         = '0;
        mem_rd_en        = 1'b0;
        mem_wr_en        = 1'b0;
        read_data_array  = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        array_word       = '0;
        k_en             = 1'b0;
        r_en             = 1'b0;
        d_en             = 1'b0;

        case (state)
            IDLE: begin
                if (miss_detected)
                    state_nxt = (WB_EN != 0 && victim_dirty) ? WB : FILL;
            end

            WB: begin
                if (vic_dirty && !k_cnt[WO_W]) begin
                    mem_wr_en       = 1'b1;
                    read_data_array = 1'b1;
                    array_word      = k_cnt[WO_W-1:0];
                    mem_addr        = ADDR_W'({vic_tag, set_index, k_cnt[WO_W-1:0]}) << BO_W;
                    k_en            = 1'b1;
                end
                if (k_last || !vic_dirty)
                    state_nxt = FILL;
            end

            FILL: begin
                // Requests run ahead of returns; the memory pipelines them.
                if (!r_cnt[WO_W]) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = ADDR_W'({line_base, r_cnt[WO_W-1:0]}) << BO_W;
                    r_en      = 1'b1;
                end
                if (memory_data_valid && !d_cnt[WO_W]) begin
                    write_data_array = 1'b1;
                    array_word       = d_cnt[WO_W-1:0];
                    d_en             = 1'b1;
                    if (d_last) begin
                        write_tag_array = 1'b1;
                        state_nxt       = IDLE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Scoreboard bench for cache_line_fill_ctrl: three configurations (default,
// fill-only, 32-bit/4-word line) each fed by a fixed-latency memory model.
module tb_cache_line_fill_ctrl;

    localparam int LAT  = 4;
    localparam int K_RD = 0;
    localparam int K_WR = 1;
    localparam int K_DW = 2;
    localparam int K_TG = 3;
    localparam int K_BZ = 4;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    typedef struct {
        int          dut;
        int          cyc;
        logic [31:0] val;
        logic [31:0] word;
    } ev_t;

    ev_t rd_q[$], wr_q[$], dw_q[$], tg_q[$], bz_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    logic end_req  = 1'b0;
    logic end_done = 1'b0;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle index: a value is "cycle n" between posedges.
    always @(posedge clk) cyc <= cyc + 1;

    logic        miss [3];
    logic        vdirty [3];
    logic        stray [3];
    logic        mvalid [3];
    logic [3:0]  pipe [3] = '{4'd0, 4'd0, 4'd0};
    logic [15:0] ma_in0, ma_in1;
    logic [31:0] ma_in2;
    logic [5:0]  vt0, vt1;
    logic [21:0] vt2;

    logic        busy [3], rd [3], wr [3], rda [3], dwr [3], tag [3];
    logic [15:0] mo0, mo1;
    logic [31:0] mo2;
    logic [2:0]  aw0, aw1;
    logic [1:0]  aw2;
    logic [31:0] addr32 [3];
    logic [31:0] aw32 [3];

    assign addr32[0] = {16'h0, mo0};
    assign addr32[1] = {16'h0, mo1};
    assign addr32[2] = mo2;
    assign aw32[0]   = {29'h0, aw0};
    assign aw32[1]   = {29'h0, aw1};
    assign aw32[2]   = {30'h0, aw2};

    // Memory model: every read request returns valid LAT cycles later.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) pipe[d] <= {pipe[d][2:0], rd[d]};
    end

    always_comb begin
        for (int d = 0; d < 3; d++) mvalid[d] = pipe[d][3] | stray[d];
    end

    cache_line_fill_ctrl #(.WB_EN(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss[0]), .miss_address(ma_in0),
        .victim_dirty(vdirty[0]), .victim_tag(vt0), .memory_data_valid(mvalid[0]),
        .fsm_busy(busy[0]), .mem_addr(mo0), .mem_rd_en(rd[0]), .mem_wr_en(wr[0]),
        .read_data_array(rda[0]), .write_data_array(dwr[0]), .write_tag_array(tag[0]),
        .array_word(aw0)
    );

    cache_line_fill_ctrl #(.WB_EN(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss[1]), .miss_address(ma_in1),
        .victim_dirty(vdirty[1]), .victim_tag(vt1), .memory_data_valid(mvalid[1]),
        .fsm_busy(busy[1]), .mem_addr(mo1), .mem_rd_en(rd[1]), .mem_wr_en(wr[1]),
        .read_data_array(rda[1]), .write_data_array(dwr[1]), .write_tag_array(tag[1]),
        .array_word(aw1)
    );

    cache_line_fill_ctrl #(.ADDR_W(32), .WORD_BYTES(4), .WORDS_PER_LINE(4),
                           .INDEX_W(6), .WB_EN(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss[2]), .miss_address(ma_in2),
        .victim_dirty(vdirty[2]), .victim_tag(vt2), .memory_data_valid(mvalid[2]),
        .fsm_busy(busy[2]), .mem_addr(mo2), .mem_rd_en(rd[2]), .mem_wr_en(wr[2]),
        .read_data_array(rda[2]), .write_data_array(dwr[2]), .write_tag_array(tag[2]),
        .array_word(aw2)
    );

    task automatic push(input int kind, input int d, input int c,
                        input logic [31:0] v, input logic [31:0] w);
        ev_t e;
        e.dut = d; e.cyc = c; e.val = v; e.word = w;
        case (kind)
            K_RD:    rd_q.push_back(e);
            K_WR:    wr_q.push_back(e);
            K_DW:    dw_q.push_back(e);
            K_TG:    tg_q.push_back(e);
            default: bz_q.push_back(e);
        endcase
    endtask

    // Expected event list for one miss accepted in cycle t0.
    // Write-back / array-write word fields carry read_data_array in bit 8.
    task automatic exp_line(input int d, input int t0, input bit wb,
                            input logic [31:0] wbb, input logic [31:0] fb,
                            input int nw, input int stride, input int nrd,
                            input int ndw, input bit tg, input int dn);
        int f0;
        f0 = t0 + 1 + (wb ? nw : 0);
        push(K_BZ, d, t0 + 1, 32'd1, NONE);
        if (wb)
            for (int k = 0; k < nw; k++)
                push(K_WR, d, t0 + 1 + k, wbb + 32'(k * stride), 32'h100 | 32'(k));
        for (int i = 0; i < nrd; i++)
            push(K_RD, d, f0 + i, fb + 32'(i * stride), NONE);
        for (int i = 0; i < ndw; i++)
            push(K_DW, d, f0 + LAT + i, 32'h0, 32'(i));
        if (tg)
            push(K_TG, d, f0 + LAT + nw - 1, 32'h0, NONE);
        push(K_BZ, d, dn, 32'd0, NONE);
    endtask

    task automatic exp_full(input int d, input int t0, input bit wb,
                            input logic [31:0] wbb, input logic [31:0] fb,
                            input int nw, input int stride);
        exp_line(d, t0, wb, wbb, fb, nw, stride, nw, nw, 1'b1,
                 t0 + 1 + (wb ? nw : 0) + LAT + nw);
    endtask

    task automatic start_miss(input int d, input logic [31:0] a, input logic dirty,
                              input logic [31:0] vt, output int t0);
        @(negedge clk);
        t0 = cyc;
        case (d)
            0:       begin ma_in0 = a[15:0]; vt0 = vt[5:0]; end
            1:       begin ma_in1 = a[15:0]; vt1 = vt[5:0]; end
            default: begin ma_in2 = a;       vt2 = vt[21:0]; end
        endcase
        vdirty[d] = dirty;
        miss[d]   = 1'b1;
    endtask

    task automatic end_miss(input int d);
        @(negedge clk);
        miss[d]   = 1'b0;
        vdirty[d] = 1'b0;
    endtask

    task automatic check_ev(input int kind, input int d, input logic [31:0] a,
                            input logic [31:0] w, input string name);
        ev_t e;
        bit  have;
        have = 1'b0;
        n_cmp++;
        case (kind)
            K_RD:    if (rd_q.size() > 0) begin e = rd_q.pop_front(); have = 1'b1; end
            K_WR:    if (wr_q.size() > 0) begin e = wr_q.pop_front(); have = 1'b1; end
            K_DW:    if (dw_q.size() > 0) begin e = dw_q.pop_front(); have = 1'b1; end
            K_TG:    if (tg_q.size() > 0) begin e = tg_q.pop_front(); have = 1'b1; end
            default: if (bz_q.size() > 0) begin e = bz_q.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_bad++;
            $display("FAIL %s unexpected: dut%0d cyc %0d addr %h word %h, nothing required",
                     name, d, cyc, a, w);
        end else if (e.dut != d || e.cyc != cyc || e.val !== a || e.word !== w) begin
            n_bad++;
            $display("FAIL %s: got dut%0d cyc %0d addr %h word %h, required dut%0d cyc %0d addr %h word %h",
                     name, d, cyc, a, w, e.dut, e.cyc, e.val, e.word);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard.
    initial begin
        logic pbusy [3];
        for (int d = 0; d < 3; d++) pbusy[d] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (busy[d] !== pbusy[d])
                    check_ev(K_BZ, d, {31'h0, busy[d]}, NONE, "busy_edge");
                pbusy[d] = busy[d];
                if (wr[d])
                    check_ev(K_WR, d, addr32[d], {23'h0, rda[d], aw32[d][7:0]}, "wb_write");
                else if (rda[d]) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rda_stray: dut%0d cyc %0d read_data_array 1, required 0", d, cyc);
                end
                if (rd[d])
                    check_ev(K_RD, d, addr32[d], NONE, "fill_read");
                if (dwr[d])
                    check_ev(K_DW, d, 32'h0, {23'h0, rda[d], aw32[d][7:0]}, "array_write");
                if (tag[d])
                    check_ev(K_TG, d, 32'h0, NONE, "tag_write");
                if (!rst_n) begin
                    n_cmp++;
                    if ((busy[d] | rd[d] | wr[d] | rda[d] | dwr[d] | tag[d]) !== 1'b0 ||
                        addr32[d] !== 32'h0 || aw32[d] !== 32'h0) begin
                        n_bad++;
                        $display("FAIL reset_outputs: dut%0d cyc %0d busy %b rd %b wr %b dwr %b tag %b addr %h, required all 0",
                                 d, cyc, busy[d], rd[d], wr[d], dwr[d], tag[d], addr32[d]);
                    end
                end
            end
            if (end_req && !end_done) begin
                n_cmp++;
                if (rd_q.size() + wr_q.size() + dw_q.size() + tg_q.size() + bz_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL leftover: %0d rd %0d wr %0d dw %0d tag %0d busy events never seen, required 0",
                             rd_q.size(), wr_q.size(), dw_q.size(), tg_q.size(), bz_q.size());
                end
                end_done = 1'b1;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int t0, tx;
        rst_n  = 1'b0;
        ma_in0 = '0; ma_in1 = '0; ma_in2 = '0;
        vt0 = '0; vt1 = '0; vt2 = '0;
        for (int d = 0; d < 3; d++) begin
            miss[d] = 1'b0; vdirty[d] = 1'b0; stray[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Clean miss at 0x3A56: reads 0x3A50..0x3A5E, tag write 11 cycles later.
        start_miss(0, 32'h3A56, 1'b0, 32'h0F, t0);
        exp_full(0, t0, 1'b0, 32'h0, 32'h3A50, 8, 2);
        end_miss(0);
        repeat (20) @(negedge clk);

        // Dirty miss, tag 0x0F index 0x25: write-back 0x3E50..0x3E5E first.
        start_miss(0, 32'h3A56, 1'b1, 32'h0F, t0);
        exp_full(0, t0, 1'b1, 32'h3E50, 32'h3A50, 8, 2);
        end_miss(0);
        // Back-to-back: new miss in the first IDLE cycle (t0+21).
        while (cyc < t0 + 20) @(negedge clk);
        start_miss(0, 32'h0102, 1'b0, 32'h00, tx);
        exp_full(0, tx, 1'b0, 32'h0, 32'h0100, 8, 2);
        end_miss(0);
        repeat (20) @(negedge clk);

        // Same dirty miss on the fill-only build: no write-back at all.
        start_miss(1, 32'h3A56, 1'b1, 32'h0F, t0);
        exp_full(1, t0, 1'b0, 32'h0, 32'h3A50, 8, 2);
        end_miss(1);
        repeat (20) @(negedge clk);

        // Miss pulsed mid-fill is ignored; then stray valids while idle.
        start_miss(0, 32'h1234, 1'b0, 32'h00, t0);
        exp_full(0, t0, 1'b0, 32'h0, 32'h1230, 8, 2);
        end_miss(0);
        while (cyc < t0 + 5) @(negedge clk);
        start_miss(0, 32'h5678, 1'b1, 32'h3F, tx);
        end_miss(0);
        repeat (12) @(negedge clk);
        for (int d = 0; d < 3; d++) stray[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) stray[d] = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in cycle 7 of a fill: 6 reads, words 0-1 written, no tag.
        start_miss(0, 32'h3A56, 1'b0, 32'h00, t0);
        exp_line(0, t0, 1'b0, 32'h0, 32'h3A50, 8, 2, 6, 2, 1'b0, t0 + 7);
        end_miss(0);
        while (cyc < t0 + 6) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        while (cyc < t0 + 8) @(negedge clk);
        rst_n = 1'b1;
        // Late valids land in cycles t0+9, t0+10 with the block idle.
        repeat (5) @(negedge clk);
        start_miss(0, 32'h3A56, 1'b0, 32'h00, t0);
        exp_full(0, t0, 1'b0, 32'h0, 32'h3A50, 8, 2);
        end_miss(0);
        repeat (20) @(negedge clk);

        // 32-bit address, 4-byte words, 4-word lines.
        start_miss(2, 32'h1234_5678, 1'b0, 32'h0, t0);
        exp_full(2, t0, 1'b0, 32'h0, 32'h1234_5670, 4, 4);
        end_miss(2);
        repeat (20) @(negedge clk);

        end_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
